// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: write-back source encodings,
// load funct3 codes and the data word width.
//
// Ports: none (package).

`ifndef WORD
`define WORD 32
`endif

package wb_pkg;

    localparam int unsigned XLEN = `WORD;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// aligned memory word, sign- or zero-extends it, and flags misaligned
// halfword/word accesses.
//
// Ports:
//   funct3_i    load width/sign code
//   offset_i    low two bits of the effective address
//   mem_word_i  aligned word read from data memory
//   data_o      extended load value
//   misalign_o  access is not naturally aligned for its width

`ifndef WORD
`define WORD 32
`endif

module load_align
    import wb_pkg::*;
(
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       offset_i,
    input  logic [`WORD-1:0] mem_word_i,
    output logic [`WORD-1:0] data_o,
    output logic             misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word_i[7:0];
        case (offset_i)
            2'd1:    byte_sel = mem_word_i[15:8];
            2'd2:    byte_sel = mem_word_i[23:16];
            2'd3:    byte_sel = mem_word_i[31:24];
            default: byte_sel = mem_word_i[7:0];
        endcase
        half_sel = offset_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    end

    always_comb begin
        data_o     = mem_word_i;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(`WORD-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(`WORD-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o     = {{(`WORD-16){half_sel[15]}}, half_sel};
                misalign_o = offset_i[0];
            end
            F3_LHU: begin
                data_o     = {{(`WORD-16){1'b0}}, half_sel};
                misalign_o = offset_i[0];
            end
            // LW and the unused codes all behave as a full-word load.
            default: begin
                data_o     = mem_word_i;
                misalign_o = (offset_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register plus write-back mux feeding the
// register-file write port, with a bypass tap, misaligned-load flag and a
// retired-instruction counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        handshake from the memory stage (ready = ~hold)
//   hold, in_flush           freeze from hazard unit / kill presented instr
//   in_reg_write, in_rd      destination control
//   in_wb_sel, in_funct3     write-back source and load width/sign
//   in_alu_result            ALU result / load effective address
//   in_mem_data              aligned memory word
//   in_pc_plus4              link value
//   we, wn, wd               register-file write port
//   fwd_valid/rd/data        bypass tap (mirrors we/wn/wd)
//   misalign                 held instruction is a misaligned load
//   instret                  retired-instruction count

`ifndef WORD
`define WORD 32
`endif

module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    input  logic             in_flush,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_funct3,
    input  logic [`WORD-1:0] in_alu_result,
    input  logic [`WORD-1:0] in_mem_data,
    input  logic [`WORD-1:0] in_pc_plus4,
    output logic             we,
    output logic [4:0]       wn,
    output logic [`WORD-1:0] wd,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [`WORD-1:0] fwd_data,
    output logic             misalign,
    output logic [CNT_W-1:0] instret
);

    logic             accept;
    logic             is_load;
    logic [`WORD-1:0] la_data;
    logic             la_misalign;
    logic [`WORD-1:0] sel_data;

    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_q,        rd_d;
    logic [`WORD-1:0] data_q,      data_d;
    logic             mis_q,       mis_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    load_align u_load_align (
        .funct3_i   (in_funct3),
        .offset_i   (in_alu_result[1:0]),
        .mem_word_i (in_mem_data),
        .data_o     (la_data),
        .misalign_o (la_misalign)
    );

    always_comb begin
        accept  = in_valid & ~hold & ~in_flush;
        is_load = (wb_sel_e'(in_wb_sel) == WB_MEM);
        case (wb_sel_e'(in_wb_sel))
            WB_MEM:  sel_data = la_data;
            WB_PC4:  sel_data = in_pc_plus4;
            default: sel_data = in_alu_result;
        endcase
    end

    // Payload fields only move on accept; a bubble just clears valid and the
    // stale payload is masked downstream.
    always_comb begin
        valid_d     = accept;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        data_d      = data_q;
        mis_d       = mis_q;
        instret_d   = instret_q;
        if (accept) begin
            reg_write_d = in_reg_write;
            rd_d        = in_rd;
            data_d      = sel_data;
            // Only a memory-sourced instruction is a load; ALU/link results
            // never trap on address bits.
            mis_d       = is_load & la_misalign;
            instret_d   = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            mis_q       <= 1'b0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            mis_q       <= mis_d;
            instret_q   <= instret_d;
        end
    end

    always_comb begin
        in_ready  = ~hold;
        misalign  = valid_q & mis_q;
        we        = valid_q & reg_write_q & (rd_q != 5'd0) & ~mis_q;
        wn        = we ? rd_q : 5'd0;
        wd        = we ? data_q : '0;
        fwd_valid = we;
        fwd_rd    = wn;
        fwd_data  = wd;
        instret   = instret_q;
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready, hold, in_flush, in_reg_write;
    logic [4:0]          in_rd;
    logic [1:0]          in_wb_sel;
    logic [2:0]          in_funct3;
    logic [31:0]         in_alu_result, in_mem_data, in_pc_plus4;
    logic                we, fwd_valid, misalign;
    logic [4:0]          wn, fwd_rd;
    logic [31:0]         wd, fwd_data;
    logic [TB_CNT_W-1:0] instret;

    int checks = 0;
    int failures = 0;
    longint unsigned cnt_exp = 0;
    logic [31:0] rf     [32];
    logic [31:0] rf_exp [32];

    writeback_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .hold(hold), .in_flush(in_flush), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_pc_plus4(in_pc_plus4), .we(we), .wn(wn), .wd(wd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .misalign(misalign), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return 32'((b >= 128) ? b - 256 : b);
            3'd4:    return 32'(b);
            3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic bit ref_misalign(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'd1 || f3 == 3'd5) return (int'(off) % 2) == 1;
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        return off != 2'd0;
    endfunction

    task automatic set_in(input bit v, input bit rw, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] mem,
                          input logic [31:0] pc4);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
        in_funct3 = f3; in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc4;
        hold = 1'b0; in_flush = 1'b0; rst = 1'b0;
    endtask

    // One clock: predict from the presented inputs, then check the WB cycle.
    task automatic tick(input string tag);
        bit acc, ld, mis, we_e;
        logic [31:0] dat;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!hold));
        acc = in_valid && !hold && !in_flush && !rst;
        ld  = (in_wb_sel == 2'd1);
        mis = ld && ref_misalign(in_funct3, in_alu_result[1:0]);
        dat = ld ? ref_load(in_funct3, in_alu_result[1:0], in_mem_data)
                 : (in_wb_sel == 2'd2) ? in_pc_plus4 : in_alu_result;
        we_e = acc && in_reg_write && (in_rd != 5'd0) && !mis;
        if (rst) cnt_exp = 0;
        else if (acc) cnt_exp = cnt_exp + 1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".we"}, 64'(we), 64'(we_e));
        chk({tag, ".wn"}, 64'(wn), we_e ? 64'(in_rd) : 64'd0);
        chk({tag, ".wd"}, 64'(wd), we_e ? 64'(dat) : 64'd0);
        chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(we_e));
        chk({tag, ".fwd_rd"}, 64'(fwd_rd), we_e ? 64'(in_rd) : 64'd0);
        chk({tag, ".fwd_data"}, 64'(fwd_data), we_e ? 64'(dat) : 64'd0);
        chk({tag, ".misalign"}, 64'(misalign), 64'(acc && mis));
        chk({tag, ".instret"}, 64'(instret), cnt_exp % (64'd1 << TB_CNT_W));
        if (we && wn != 5'd0) rf[wn] = wd;
        if (we_e) rf_exp[in_rd] = dat;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin rf[i] = '0; rf_exp[i] = '0; end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick("idle");

        // ALU write then x0 write
        set_in(1, 1, 5'd5, 2'd0, 3'd0, 32'hDEADBEEF, 0, 0);
        tick("alu_x5");
        set_in(1, 1, 5'd0, 2'd0, 3'd0, 32'h12345678, 0, 0);
        tick("alu_x0");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rf_x5", 64'(rf[5]), 64'h0000_0000_DEADBEEF);
        chk("instret_2", 64'(instret), 64'd2);

        // Load alignment
        set_in(1, 1, 5'd6, 2'd1, 3'b000, 32'h1001, 32'h80F1_7F02, 0);
        tick("lb1");  chk("lb1_val", 64'(wd), 64'h0000007F);
        set_in(1, 1, 5'd7, 2'd1, 3'b000, 32'h1003, 32'h80F1_7F02, 0);
        tick("lb3");  chk("lb3_val", 64'(wd), 64'hFFFFFF80);
        set_in(1, 1, 5'd8, 2'd1, 3'b100, 32'h1003, 32'h80F1_7F02, 0);
        tick("lbu3"); chk("lbu3_val", 64'(wd), 64'h00000080);
        set_in(1, 1, 5'd9, 2'd1, 3'b001, 32'h1002, 32'h80F1_7F02, 0);
        tick("lh2");  chk("lh2_val", 64'(wd), 64'hFFFF80F1);
        set_in(1, 1, 5'd10, 2'd1, 3'b101, 32'h1002, 32'h80F1_7F02, 0);
        tick("lhu2"); chk("lhu2_val", 64'(wd), 64'h000080F1);

        // Misaligned loads
        set_in(1, 1, 5'd11, 2'd1, 3'b010, 32'h1002, 32'h80F1_7F02, 0);
        tick("lw_mis"); chk("lw_mis_flag", 64'(misalign), 64'd1);
        set_in(1, 1, 5'd12, 2'd1, 3'b001, 32'h1001, 32'h80F1_7F02, 0);
        tick("lh_mis"); chk("lh_mis_flag", 64'(misalign), 64'd1);

        // JAL under hold for two cycles
        set_in(1, 1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h104);
        hold = 1'b1;
        tick("jal_hold0");
        tick("jal_hold1");
        hold = 1'b0;
        tick("jal_go");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick("jal_after");
        chk("rf_x1", 64'(rf[1]), 64'h104);

        // Flush with valid, then reset with valid
        set_in(1, 1, 5'd13, 2'd0, 3'd0, 32'hAAAA5555, 0, 0);
        in_flush = 1'b1;
        tick("flush");
        set_in(1, 1, 5'd14, 2'd0, 3'd0, 32'h5555AAAA, 0, 0);
        rst = 1'b1;
        tick("rst_inflight");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick("post_rst");
        chk("rst_instret0", 64'(instret), 64'd0);

        // Random traffic; narrow counter wraps along the way
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   5'($urandom), 2'($urandom), 3'($urandom),
                   $urandom, $urandom, $urandom);
            hold     = ($urandom_range(0, 6) == 0);
            in_flush = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick("rand");
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick("drain");

        for (int r = 0; r < 32; r++)
            chk($sformatf("rf_final_x%0d", r), 64'(rf[r]), 64'(rf_exp[r]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
